// File: rtl/line_draw_scheduler.sv
// Purpose: queues line-draw commands, runs them one at a time through the Line engine, and arbitrates the frame-buffer write port.
// Latency: 2 cycles from a command push into an empty, idle block to oLineGo; 1 cycle from an engine or host pixel to oWrEn.
// Backpressure: oCmdReady drops while the command FIFO is full; a host request waits while the engine writes.
module line_draw_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLOR_W    = 8,
  parameter int ADR_W      = 16
) (
  input  logic                        iClk,
  input  logic                        iRst_n,
  input  logic                        iCmdValid,
  output logic                        oCmdReady,
  input  logic [7:0]                  iCmdX0,
  input  logic [7:0]                  iCmdY0,
  input  logic [7:0]                  iCmdX1,
  input  logic [7:0]                  iCmdY1,
  input  logic [COLOR_W-1:0]          iCmdColor,
  input  logic                        iFlush,
  output logic                        oLineGo,
  output logic [7:0]                  oLineX0,
  output logic [7:0]                  oLineY0,
  output logic [7:0]                  oLineX1,
  output logic [7:0]                  oLineY1,
  input  logic                        iLineDone,
  input  logic [ADR_W-1:0]            iLineAdr,
  input  logic                        iLineWrEn,
  input  logic                        iHostReq,
  input  logic [ADR_W-1:0]            iHostAdr,
  input  logic [COLOR_W-1:0]          iHostData,
  output logic                        oHostGnt,
  output logic [ADR_W-1:0]            oAdr,
  output logic [COLOR_W-1:0]          oWrData,
  output logic                        oWrEn,
  output logic                        oBusy,
  output logic [$clog2(FIFO_DEPTH):0] oCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [7:0]         x0;
    logic [7:0]         y0;
    logic [7:0]         x1;
    logic [7:0]         y1;
    logic [COLOR_W-1:0] color;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_DRAW
  } state_t;

  cmd_t               fifo_q [FIFO_DEPTH];
  cmd_t               cmd_in;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  state_t             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [COLOR_W-1:0] wdat_q, wdat_d;
  logic               wen_q, wen_d;
  logic               full, empty, push, pop;

  assign cmd_in = '{x0: iCmdX0, y0: iCmdY0, x1: iCmdX1, y1: iCmdY1, color: iCmdColor};
  assign full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  // A flush wins over both a push and a pop in the same cycle.
  assign push   = iCmdValid && !full && !iFlush;
  assign pop    = (state_q == S_IDLE) && !empty && !iFlush;

  // Command storage; contents are don't-care while count_q says the slot is empty.
  always_ff @(posedge iClk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= cmd_in;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (iFlush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Sequencer: pop a command, pulse go, skip the stale done in ARM, then wait for done in DRAW.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cmd_d   = fifo_q[rd_ptr_q];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_ARM;
      // The engine still shows the previous line's done here; ignore it.
      S_ARM:    state_d = S_DRAW;
      S_DRAW: begin
        if (iLineDone) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Write-port arbitration: the engine cannot stall, so it always beats the host.
  always_comb begin
    adr_d  = adr_q;
    wdat_d = wdat_q;
    wen_d  = 1'b0;
    if (iLineWrEn) begin
      adr_d  = iLineAdr;
      wdat_d = cmd_q.color;
      wen_d  = 1'b1;
    end else if (iHostReq) begin
      adr_d  = iHostAdr;
      wdat_d = iHostData;
      wen_d  = 1'b1;
    end
  end

  // State, FIFO bookkeeping, held command and registered write port.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      wen_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      wen_q    <= wen_d;
    end
  end

  assign oCmdReady = !full;
  assign oCount    = count_q;
  assign oLineGo   = (state_q == S_LAUNCH);
  assign oLineX0   = cmd_q.x0;
  assign oLineY0   = cmd_q.y0;
  assign oLineX1   = cmd_q.x1;
  assign oLineY1   = cmd_q.y1;
  // Grant is masked while reset is asserted so nothing is consumed during reset.
  assign oHostGnt  = iRst_n && iHostReq && !iLineWrEn;
  assign oAdr      = adr_q;
  assign oWrData   = wdat_q;
  assign oWrEn     = wen_q;
  assign oBusy     = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Bench for line_draw_scheduler: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_line_draw_scheduler;

  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int AW    = 16;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iCmdValid;
  logic          oCmdReady;
  logic [7:0]    iCmdX0, iCmdY0, iCmdX1, iCmdY1;
  logic [CW-1:0] iCmdColor;
  logic          iFlush;
  logic          oLineGo;
  logic [7:0]    oLineX0, oLineY0, oLineX1, oLineY1;
  logic          iLineDone;
  logic [AW-1:0] iLineAdr;
  logic          iLineWrEn;
  logic          iHostReq;
  logic [AW-1:0] iHostAdr;
  logic [CW-1:0] iHostData;
  logic          oHostGnt;
  logic [AW-1:0] oAdr;
  logic [CW-1:0] oWrData;
  logic          oWrEn;
  logic          oBusy;
  logic [2:0]    oCount;

  line_draw_scheduler #(.FIFO_DEPTH(DEPTH), .COLOR_W(CW), .ADR_W(AW)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
    .iCmdX0(iCmdX0), .iCmdY0(iCmdY0), .iCmdX1(iCmdX1), .iCmdY1(iCmdY1),
    .iCmdColor(iCmdColor), .iFlush(iFlush),
    .oLineGo(oLineGo), .oLineX0(oLineX0), .oLineY0(oLineY0), .oLineX1(oLineX1), .oLineY1(oLineY1),
    .iLineDone(iLineDone), .iLineAdr(iLineAdr), .iLineWrEn(iLineWrEn),
    .iHostReq(iHostReq), .iHostAdr(iHostAdr), .iHostData(iHostData), .oHostGnt(oHostGnt),
    .oAdr(oAdr), .oWrData(oWrData), .oWrEn(oWrEn), .oBusy(oBusy), .oCount(oCount)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [7:0]    x0, y0, x1, y1;
    logic [CW-1:0] color;
  } cmd_s;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;

  // Reference model: queued commands, line in flight, phase counted in cycles since the pop.
  cmd_s          m_fifo[$];
  cmd_s          m_cur;
  int            m_phase = 0;   // 0 idle, 1 go cycle, 2 arm cycle, 3 drawing
  logic [AW-1:0] m_adr   = '0;
  logic [CW-1:0] m_dat   = '0;
  logic          m_wen   = 1'b0;

  // Stimulus sources.
  cmd_s          src[$];
  bit            src_en  = 1'b1;
  int            src_pct = 100;
  bit            h_pend  = 1'b0;
  logic [AW-1:0] h_adr   = '0;
  logic [CW-1:0] h_dat   = '0;
  int            host_pct = 0;
  int            e_left  = 0;
  int            e_x     = 0;
  int            e_gap   = 0;
  bit            e_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_cmd(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] y1,
                         input int len, input logic [CW-1:0] col);
    cmd_s c;
    c.x0 = x0; c.y0 = y0; c.x1 = 8'(int'(x0) + len - 1); c.y1 = y1; c.color = col;
    src.push_back(c);
  endtask

  task automatic present_src();
    iCmdValid = 1'b1;
    iCmdX0 = src[0].x0; iCmdY0 = src[0].y0; iCmdX1 = src[0].x1; iCmdY1 = src[0].y1;
    iCmdColor = src[0].color;
  endtask

  // Drives all inputs for the coming cycle; the engine stub follows the model's line phase.
  task automatic drive_next();
    iFlush = 1'b0;
    if (src_en && src.size() > 0 && int'($urandom_range(99)) < src_pct) present_src();
    else iCmdValid = 1'b0;
    if (!h_pend && int'($urandom_range(99)) < host_pct) begin
      h_pend = 1'b1; h_adr = 16'($urandom); h_dat = 8'($urandom);
    end
    iHostReq = h_pend; iHostAdr = h_adr; iHostData = h_dat;
    if (m_phase == 2) begin
      // Engine has just taken go and still shows done from before.
      e_left = int'(m_cur.x1) - int'(m_cur.x0) + 1;
      e_x = int'(m_cur.x0);
      iLineDone = 1'b1; iLineWrEn = 1'b0;
    end else if (m_phase == 3) begin
      iLineDone = 1'b0; iLineWrEn = 1'b0;
      if (e_left > 0) begin
        if (int'($urandom_range(99)) >= e_gap) begin
          iLineWrEn = 1'b1;
          iLineAdr = {m_cur.y0, 8'(e_x)};
          e_x++; e_left--;
        end
      end else begin
        iLineDone = !e_stall;
      end
    end else begin
      iLineDone = 1'b1; iLineWrEn = 1'b0;
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs, drive next inputs.
  task automatic cycle();
    bit acc, pop_now, gnt;
    #1;
    chk("cmd_ready", 32'(oCmdReady), 32'(m_fifo.size() < DEPTH));
    gnt = iHostReq && !iLineWrEn;
    chk("host_gnt", 32'(oHostGnt), 32'(gnt));
    acc = iCmdValid && (m_fifo.size() < DEPTH) && !iFlush;
    pop_now = (m_phase == 0) && (m_fifo.size() > 0) && !iFlush;
    if (iLineWrEn) begin
      m_adr = iLineAdr; m_dat = m_cur.color; m_wen = 1'b1;
    end else if (iHostReq) begin
      m_adr = iHostAdr; m_dat = iHostData; m_wen = 1'b1;
    end else begin
      m_wen = 1'b0;
    end
    if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2) m_phase = 3;
    else if (m_phase == 3 && iLineDone) m_phase = 0;
    if (iFlush) m_fifo.delete();
    if (pop_now) begin
      m_cur = m_fifo.pop_front();
      m_phase = 1;
    end
    if (acc) begin
      m_fifo.push_back(src[0]);
      void'(src.pop_front());
    end
    if (gnt) h_pend = 1'b0;
    @(posedge iClk);
    #1;
    chk("line_go", 32'(oLineGo), 32'(m_phase == 1));
    if (m_phase != 0) begin
      chk("line_x0", 32'(oLineX0), 32'(m_cur.x0));
      chk("line_y0", 32'(oLineY0), 32'(m_cur.y0));
      chk("line_x1", 32'(oLineX1), 32'(m_cur.x1));
      chk("line_y1", 32'(oLineY1), 32'(m_cur.y1));
    end
    chk("count", 32'(oCount), 32'(m_fifo.size()));
    chk("busy", 32'(oBusy), 32'(m_phase != 0 || m_fifo.size() != 0));
    chk("wr_en", 32'(oWrEn), 32'(m_wen));
    chk("wr_adr", 32'(oAdr), 32'(m_adr));
    chk("wr_data", 32'(oWrData), 32'(m_dat));
    if (oWrEn === 1'b1) nwr++;
    @(negedge iClk);
    drive_next();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_phase != 0 || m_fifo.size() != 0 || src.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_go"},    32'(oLineGo),   32'd0);
    chk({tag, "_wen"},   32'(oWrEn),     32'd0);
    chk({tag, "_gnt"},   32'(oHostGnt),  32'd0);
    chk({tag, "_busy"},  32'(oBusy),     32'd0);
    chk({tag, "_count"}, 32'(oCount),    32'd0);
    chk({tag, "_ready"}, 32'(oCmdReady), 32'd1);
    chk({tag, "_adr"},   32'(oAdr),      32'd0);
    chk({tag, "_data"},  32'(oWrData),   32'd0);
    chk({tag, "_x0"},    32'(oLineX0),   32'd0);
    chk({tag, "_y0"},    32'(oLineY0),   32'd0);
    chk({tag, "_x1"},    32'(oLineX1),   32'd0);
    chk({tag, "_y1"},    32'(oLineY1),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    iRst_n = 1'b0; iCmdValid = 1'b0; iCmdX0 = '0; iCmdY0 = '0; iCmdX1 = '0; iCmdY1 = '0;
    iCmdColor = '0; iFlush = 1'b0; iLineDone = 1'b1; iLineAdr = '0; iLineWrEn = 1'b0;
    iHostReq = 1'b0; iHostAdr = '0; iHostData = '0;
    #3;
    check_reset("por");
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    drive_next();

    // Single horizontal line, colour 0x5A, engine writing every cycle.
    nwr = 0;
    add_cmd(8'd0, 8'd0, 8'd0, 4, 8'h5A);
    drive_next();
    cycle();
    cycle();
    chk("t1_go_two_cycles", 32'(oLineGo), 32'd1);
    cycle();
    cycle();
    chk("t6_arm_done_ignored", 32'(oBusy), 32'd1);
    drain(200);
    chk("t1_write_count", 32'(nwr), 32'd4);
    chk("t1_busy_low", 32'(oBusy), 32'd0);

    // Stalled engine: six back-to-back pushes fill the FIFO behind the in-flight head.
    e_stall = 1'b1;
    for (int i = 0; i < 6; i++) add_cmd(8'(i * 10), 8'(i), 8'(i + 1), 3, 8'(8'h10 + i));
    drive_next();
    repeat (10) cycle();
    chk("t2_count_full", 32'(oCount), 32'd4);
    chk("t2_ready_low", 32'(oCmdReady), 32'd0);
    e_stall = 1'b0;
    drain(500);

    // Host request held while the engine writes continuously.
    add_cmd(8'h20, 8'h40, 8'h41, 6, 8'hC3);
    drive_next();
    n = 0;
    while (m_phase != 3 && n < 20) begin cycle(); n++; end
    chk("t3_reach_draw", 32'(n < 20), 32'd1);
    h_pend = 1'b1; h_adr = 16'h1234; h_dat = 8'h77;
    iHostReq = 1'b1; iHostAdr = h_adr; iHostData = h_dat;
    n = 0;
    while (h_pend && n < 50) begin cycle(); n++; end
    chk("t3_grant_budget", 32'(n < 50), 32'd1);
    chk("t3_host_adr", 32'(oAdr), 32'h1234);
    chk("t3_host_data", 32'(oWrData), 32'h77);
    chk("t3_host_wen", 32'(oWrEn), 32'd1);
    drain(200);

    // Push and pop together at occupancy 2, then a flush racing a push.
    e_stall = 1'b1;
    for (int i = 0; i < 3; i++) add_cmd(8'(100 + i * 8), 8'(7 + i), 8'd9, 2, 8'(8'hA0 + i));
    drive_next();
    repeat (8) cycle();
    chk("t4_pre_count", 32'(oCount), 32'd2);
    src_en = 1'b0;
    add_cmd(8'd200, 8'd50, 8'd51, 3, 8'hEE);
    e_stall = 1'b0;
    n = 0;
    while (m_phase != 0 && n < 50) begin cycle(); n++; end
    chk("t4_idle_budget", 32'(n < 50), 32'd1);
    e_stall = 1'b1;
    present_src();
    cycle();
    chk("t4_pushpop_count", 32'(oCount), 32'd2);
    repeat (4) cycle();
    add_cmd(8'd30, 8'd31, 8'd32, 2, 8'h3C);
    present_src();
    iFlush = 1'b1;
    cycle();
    chk("t4_flush_count", 32'(oCount), 32'd0);
    src.delete();
    src_en = 1'b1;
    e_stall = 1'b0;
    drain(200);
    chk("t4_inflight_done", 32'(oBusy), 32'd0);

    // Asynchronous reset in the middle of a draw.
    e_stall = 1'b1;
    add_cmd(8'd60, 8'd61, 8'd62, 3, 8'h99);
    add_cmd(8'd70, 8'd71, 8'd72, 3, 8'h98);
    drive_next();
    n = 0;
    while (!(m_phase == 3 && m_fifo.size() == 1) && n < 30) begin cycle(); n++; end
    chk("t5_reach_draw", 32'(n < 30), 32'd1);
    h_pend = 1'b1; iHostReq = 1'b1;
    #2 iRst_n = 1'b0;
    #1 check_reset("t5");
    m_fifo.delete(); m_phase = 0; m_adr = '0; m_dat = '0; m_wen = 1'b0;
    src.delete(); e_left = 0; e_stall = 1'b0; h_pend = 1'b0;
    iCmdValid = 1'b0; iHostReq = 1'b0; iLineWrEn = 1'b0; iLineDone = 1'b1;
    repeat (2) @(posedge iClk);
    #1 chk("t5_held_busy", 32'(oBusy), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    add_cmd(8'd5, 8'd6, 8'd7, 2, 8'h42);
    drive_next();
    cycle();
    cycle();
    chk("t5_go_after_reset", 32'(oLineGo), 32'd1);
    drain(200);

    // Randomized traffic: gappy engine, random host writes, irregular command arrivals.
    e_gap = 30; host_pct = 25; src_pct = 60;
    for (int i = 0; i < 40; i++)
      add_cmd(8'($urandom_range(250)), 8'($urandom), 8'($urandom), int'($urandom_range(1, 5)), 8'($urandom));
    drive_next();
    drain(3000);
    host_pct = 0;
    repeat (5) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
